// File: rtl/proc_ctrl_pkg.sv
// Shared types and constants for the proc_ctrl_fsm control sequencer.
package proc_ctrl_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned CLASS_W = 3;
  localparam int unsigned WSEL_W  = 2;
  localparam int unsigned CAUSE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    EXECUTE   = 4'd3,
    MEMORY    = 4'd4,
    WRITEBACK = 4'd5,
    HALT      = 4'd6,
    TRAP      = 4'd7
  } proc_ctrl_state_t;

  typedef enum logic [CLASS_W-1:0] {
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JAL,
    CLS_HALT,
    CLS_ILLEGAL
  } instr_class_t;

  localparam logic [6:0] OPC_ALU_R  = 7'h33;
  localparam logic [6:0] OPC_ALU_I  = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_HALT   = 7'h73;

  localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL = 2'd0;
  localparam logic [CAUSE_W-1:0] CAUSE_IMEM_TO = 2'd1;
  localparam logic [CAUSE_W-1:0] CAUSE_DMEM_TO = 2'd2;

  localparam logic [WSEL_W-1:0] WSEL_ALU = 2'd0;
  localparam logic [WSEL_W-1:0] WSEL_MEM = 2'd1;
  localparam logic [WSEL_W-1:0] WSEL_PC4 = 2'd2;

  // Register-file write source for a retiring instruction class.
  function automatic logic [WSEL_W-1:0] wsel_of(instr_class_t cls);
    case (cls)
      CLS_LOAD: wsel_of = WSEL_MEM;
      CLS_JAL:  wsel_of = WSEL_PC4;
      default:  wsel_of = WSEL_ALU;
    endcase
  endfunction

endpackage

// File: rtl/proc_ctrl_decoder.sv
// Combinational opcode classifier for proc_ctrl_fsm.
module proc_ctrl_decoder
  import proc_ctrl_pkg::*;
#(
  parameter int unsigned OPC_W = 7
) (
  input  logic [OPC_W-1:0] opc,
  output instr_class_t     cls_c
);

  always_comb begin
    cls_c = CLS_ILLEGAL;
    if (opc == OPC_W'(OPC_ALU_R) || opc == OPC_W'(OPC_ALU_I)) cls_c = CLS_ALU;
    else if (opc == OPC_W'(OPC_LOAD))   cls_c = CLS_LOAD;
    else if (opc == OPC_W'(OPC_STORE))  cls_c = CLS_STORE;
    else if (opc == OPC_W'(OPC_BRANCH)) cls_c = CLS_BRANCH;
    else if (opc == OPC_W'(OPC_JAL))    cls_c = CLS_JAL;
    else if (opc == OPC_W'(OPC_HALT))   cls_c = CLS_HALT;
  end

endmodule

// File: rtl/proc_ctrl_fsm.sv
// Multi-cycle processor control sequencer with memory-timeout trap and halt/resume.
// Define PROC_CTRL_PERF_CNT_EN to add the cycle_cnt / instret_cnt performance counters.
module proc_ctrl_fsm
  import proc_ctrl_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     ILEN        = 32,
  parameter int unsigned     OPC_W       = 7,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int unsigned     MEM_TIMEOUT = 16
`ifdef PROC_CTRL_PERF_CNT_EN
  , parameter int unsigned   CNT_W       = 32
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_rvalid,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_tgt,
  output logic [XLEN-1:0] pc,
  output logic [ILEN-1:0] ir,
  output logic            alu_en,
  output logic            rf_we,
  output logic [1:0]      rf_wsel,
  output logic [3:0]      state,
  output logic            halted,
  output logic            trap,
`ifdef PROC_CTRL_PERF_CNT_EN
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
`endif
  output logic [1:0]      trap_cause
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  proc_ctrl_state_t     state_q, state_d;
  logic [XLEN-1:0]      pc_q, pc_d, pc_plus4;
  logic [ILEN-1:0]      ir_q, ir_d;
  logic [CAUSE_W-1:0]   cause_q, cause_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic                 wait_hit;
  instr_class_t         cls;

  proc_ctrl_decoder #(.OPC_W(OPC_W)) u_dec (
    .opc   (ir_q[OPC_W-1:0]),
    .cls_c (cls)
  );

  assign pc_plus4   = pc_q + XLEN'(4);
  assign wait_hit   = (MEM_TIMEOUT != 0) && (wait_q == WAIT_W'(MEM_TIMEOUT));
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign ir         = ir_q;
  assign state      = state_q;
  assign trap_cause = cause_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      cause_q <= CAUSE_ILLEGAL;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cause_q <= cause_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state, register updates and strobes; rvalid is checked before the timeout so it wins.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    cause_d  = cause_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    alu_en   = 1'b0;
    rf_we    = 1'b0;
    rf_wsel  = WSEL_ALU;
    halted   = 1'b0;
    trap     = 1'b0;
    unique case (state_q)
      IDLE: if (start) state_d = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_rvalid) begin
          ir_d    = imem_rdata;
          state_d = DECODE;
        end else if (wait_hit) begin
          state_d = TRAP;
          cause_d = CAUSE_IMEM_TO;
        end
      end
      DECODE: begin
        if (cls == CLS_HALT) state_d = HALT;
        else if (cls == CLS_ILLEGAL) begin
          state_d = TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else state_d = EXECUTE;
      end
      EXECUTE: begin
        alu_en = 1'b1;
        if (cls == CLS_LOAD || cls == CLS_STORE) state_d = MEMORY;
        else if (cls == CLS_BRANCH) begin
          pc_d    = branch_taken ? branch_tgt : pc_plus4;
          state_d = FETCH;
        end else state_d = WRITEBACK;
      end
      MEMORY: begin
        dmem_req = 1'b1;
        dmem_we  = (cls == CLS_STORE);
        if (dmem_rvalid) begin
          if (cls == CLS_STORE) begin
            pc_d    = pc_plus4;
            state_d = FETCH;
          end else state_d = WRITEBACK;
        end else if (wait_hit) begin
          state_d = TRAP;
          cause_d = CAUSE_DMEM_TO;
        end
      end
      WRITEBACK: begin
        rf_we   = 1'b1;
        rf_wsel = wsel_of(cls);
        pc_d    = (cls == CLS_JAL) ? branch_tgt : pc_plus4;
        state_d = FETCH;
      end
      HALT: begin
        halted = 1'b1;
        if (start) begin
          pc_d    = pc_plus4;
          state_d = FETCH;
        end
      end
      TRAP: trap = 1'b1;
      default: state_d = IDLE;
    endcase
    wait_d = wait_q;
    if (state_d != state_q) wait_d = '0;
    else if ((state_q == FETCH || state_q == MEMORY) && MEM_TIMEOUT != 0) wait_d = wait_q + WAIT_W'(1);
  end

`ifdef PROC_CTRL_PERF_CNT_EN
  // Retire = re-entering FETCH from the back half of the pipeline sequence.
  logic retire;
  assign retire = (state_d == FETCH) && (state_q inside {EXECUTE, MEMORY, WRITEBACK});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (!(state_q inside {IDLE, HALT, TRAP})) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (retire) instret_cnt <= instret_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Self-checking bench for proc_ctrl_fsm: per-instruction reference model plus directed trap/halt/reset scenarios.
module tb_proc_ctrl_fsm;

  localparam logic [3:0] ST_IDLE = 4'd0, ST_FETCH = 4'd1, ST_MEMORY = 4'd4,
                         ST_HALT = 4'd6, ST_TRAP = 4'd7;
  localparam int CL_ALU = 0, CL_LOAD = 1, CL_STORE = 2, CL_BRANCH = 3, CL_JAL = 4, CL_HALT = 5, CL_ILL = 6;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic        imem_req, imem_rvalid = 1'b0, dmem_req, dmem_we, dmem_rvalid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0, branch_tgt = '0, pc, ir;
  logic        branch_taken = 1'b0, alu_en, rf_we, halted, trap;
  logic [1:0]  rf_wsel, trap_cause;
  logic [3:0]  state;

  int checks = 0, failures = 0;
  logic [31:0] model_pc = '0;

  typedef struct {
    int cycles; int imem_reqs; int dmem_reqs; int dmem_wes; int alu_ens; int rf_wes;
    logic [1:0] wsel; logic [3:0] end_state; bit timed_out;
  } obs_t;

  proc_ctrl_fsm dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_rvalid(dmem_rvalid),
    .branch_taken(branch_taken), .branch_tgt(branch_tgt),
    .pc(pc), .ir(ir), .alu_en(alu_en), .rf_we(rf_we), .rf_wsel(rf_wsel),
    .state(state), .halted(halted), .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  // Reference model: instruction-level effects derived from the opcode rules.
  function automatic int cls_of(logic [6:0] op);
    case (op)
      7'h33, 7'h13: return CL_ALU;
      7'h03: return CL_LOAD;
      7'h23: return CL_STORE;
      7'h63: return CL_BRANCH;
      7'h6F: return CL_JAL;
      7'h73: return CL_HALT;
      default: return CL_ILL;
    endcase
  endfunction

  function automatic int exp_cycles(int c, int iw, int dw);
    case (c)
      CL_BRANCH: return iw + 3;
      CL_STORE:  return iw + dw + 4;
      CL_LOAD:   return iw + dw + 5;
      default:   return iw + 4;
    endcase
  endfunction

  function automatic logic [31:0] exp_pc(int c, logic [31:0] p, logic tk, logic [31:0] tgt);
    if (c == CL_JAL || (c == CL_BRANCH && tk)) return tgt;
    return p + 32'd4;
  endfunction

  // Runs one instruction from a FETCH cycle until the next FETCH entry (or HALT/TRAP), recording strobes.
  task automatic exec_instr(input logic [31:0] instr, input int iw, input int dw,
                            input logic tk, input logic [31:0] tgt, output obs_t o);
    int fc = 0, mc = 0;
    bit left = 0, done = 0;
    o.cycles = 0; o.imem_reqs = 0; o.dmem_reqs = 0; o.dmem_wes = 0;
    o.alu_ens = 0; o.rf_wes = 0; o.wsel = 2'd0;
    imem_rdata = instr; branch_taken = tk; branch_tgt = tgt;
    for (int n = 0; n < 100 && !done; n++) begin
      if (imem_req) o.imem_reqs++;
      if (dmem_req) begin o.dmem_reqs++; if (dmem_we) o.dmem_wes++; end
      if (alu_en) o.alu_ens++;
      if (rf_we) begin o.rf_wes++; o.wsel = rf_wsel; end
      start = 1'($urandom);
      if (state == ST_FETCH) begin imem_rvalid = (fc == iw); fc++; end
      else imem_rvalid = 1'($urandom);
      if (state == ST_MEMORY) begin dmem_rvalid = (mc == dw); mc++; end
      else dmem_rvalid = 1'($urandom);
      @(negedge clk);
      o.cycles++;
      if (state != ST_FETCH) left = 1;
      if ((left && state == ST_FETCH) || state == ST_HALT || state == ST_TRAP) done = 1;
    end
    start = 0; imem_rvalid = 0; dmem_rvalid = 0;
    o.end_state = state;
    o.timed_out = !done;
  endtask

  task automatic do_reset();
    rst = 1; start = 0; imem_rvalid = 0; dmem_rvalid = 0;
    @(negedge clk); rst = 0; @(negedge clk);
    model_pc = '0;
  endtask

  task automatic go();
    start = 1; @(negedge clk); start = 0;
  endtask

  task automatic test_reset();
    rst = 1; @(negedge clk); @(negedge clk);
    checks++; if (state !== ST_IDLE) begin failures++; $display("FAIL reset_state: got %0d want %0d", state, ST_IDLE); end
    checks++; if (pc !== 32'h0 || ir !== 32'h0) begin failures++; $display("FAIL reset_pc_ir: got pc=%0h ir=%0h want 0/0", pc, ir); end
    checks++; if ({imem_req, dmem_req, dmem_we, alu_en, rf_we, halted, trap, trap_cause} !== 9'h0) begin
      failures++; $display("FAIL reset_flags: got %b want 0", {imem_req, dmem_req, dmem_we, alu_en, rf_we, halted, trap, trap_cause}); end
    rst = 0; @(negedge clk);
    go();
    checks++; if (state !== ST_FETCH || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failures++; $display("FAIL start_fetch: got st=%0d req=%b addr=%0h want 1/1/0", state, imem_req, imem_addr); end
  endtask

  task automatic test_alu();
    obs_t o;
    exec_instr(32'h0000_0033, 0, 0, 1'b0, 32'h0, o);
    checks++; if (o.cycles !== 4 || o.end_state !== ST_FETCH) begin failures++; $display("FAIL alu_latency: got %0d st=%0d want 4/1", o.cycles, o.end_state); end
    checks++; if (o.rf_wes !== 1 || o.wsel !== 2'd0) begin failures++; $display("FAIL alu_rf: got we=%0d sel=%0d want 1/0", o.rf_wes, o.wsel); end
    checks++; if (pc !== 32'h4) begin failures++; $display("FAIL alu_pc: got %0h want 4", pc); end
    model_pc = 32'h4;
  endtask

  task automatic test_load();
    obs_t o;
    exec_instr({$urandom} & 32'hFFFF_FF80 | 32'h03, 0, 3, 1'b0, 32'h0, o);
    checks++; if (o.dmem_reqs !== 4 || o.dmem_wes !== 0) begin failures++; $display("FAIL load_dmem: got req=%0d we=%0d want 4/0", o.dmem_reqs, o.dmem_wes); end
    checks++; if (o.rf_wes !== 1 || o.wsel !== 2'd1) begin failures++; $display("FAIL load_rf: got we=%0d sel=%0d want 1/1", o.rf_wes, o.wsel); end
    checks++; if (pc !== 32'h8 || o.cycles !== 8) begin failures++; $display("FAIL load_pc: got pc=%0h cyc=%0d want 8/8", pc, o.cycles); end
    model_pc = 32'h8;
  endtask

  task automatic test_branch();
    obs_t o;
    exec_instr(32'h0000_006F, 0, 0, 1'b0, 32'h10, o);
    checks++; if (pc !== 32'h10 || o.wsel !== 2'd2) begin failures++; $display("FAIL jal: got pc=%0h sel=%0d want 10/2", pc, o.wsel); end
    exec_instr(32'h0000_0063, 0, 0, 1'b1, 32'h40, o);
    checks++; if (pc !== 32'h40 || o.rf_wes !== 0 || o.cycles !== 3) begin
      failures++; $display("FAIL branch_taken: got pc=%0h we=%0d cyc=%0d want 40/0/3", pc, o.rf_wes, o.cycles); end
    exec_instr(32'h0000_006F, 0, 0, 1'b0, 32'h10, o);
    exec_instr(32'h0000_0063, 0, 0, 1'b0, 32'h40, o);
    checks++; if (pc !== 32'h14 || o.rf_wes !== 0) begin failures++; $display("FAIL branch_not_taken: got pc=%0h we=%0d want 14/0", pc, o.rf_wes); end
    exec_instr(32'h0000_006F, 0, 0, 1'b0, 32'hFFFF_FFFC, o);
    exec_instr(32'h0000_0013, 0, 0, 1'b0, 32'h0, o);
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL pc_wrap: got %0h want 0", pc); end
    model_pc = 32'h0;
  endtask

  // Random instruction stream; also boundary waits of exactly MEM_TIMEOUT cycles, where rvalid must win.
  task automatic test_random();
    logic [6:0] ops [6] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F};
    obs_t o;
    for (int i = 0; i < 42; i++) begin
      logic [31:0] instr, tgt;
      logic tk;
      int c, iw, dw;
      instr = ($urandom & 32'hFFFF_FF80) | {25'h0, ops[$urandom_range(0, 5)]};
      iw = (i == 40) ? 16 : int'($urandom_range(0, 4));
      dw = (i == 41) ? 16 : int'($urandom_range(0, 4));
      if (i == 41) instr = 32'h0000_0003;
      tk = 1'($urandom); tgt = $urandom;
      c = cls_of(instr[6:0]);
      exec_instr(instr, iw, dw, tk, tgt, o);
      model_pc = exp_pc(c, model_pc, tk, tgt);
      checks++; if (o.timed_out || o.end_state !== ST_FETCH || trap !== 1'b0) begin
        failures++; $display("FAIL rnd%0d_end: got st=%0d to=%0d trap=%b want FETCH", i, o.end_state, o.timed_out, trap); end
      checks++; if (o.cycles !== exp_cycles(c, iw, dw)) begin failures++; $display("FAIL rnd%0d_cycles: got %0d want %0d", i, o.cycles, exp_cycles(c, iw, dw)); end
      checks++; if (pc !== model_pc || imem_addr !== model_pc) begin failures++; $display("FAIL rnd%0d_pc: got %0h want %0h", i, pc, model_pc); end
      checks++; if (ir !== instr) begin failures++; $display("FAIL rnd%0d_ir: got %0h want %0h", i, ir, instr); end
      checks++; if (o.imem_reqs !== iw + 1 || o.alu_ens !== 1) begin failures++; $display("FAIL rnd%0d_fetch: got req=%0d alu=%0d want %0d/1", i, o.imem_reqs, o.alu_ens, iw + 1); end
      checks++; if (o.rf_wes !== ((c == CL_ALU || c == CL_LOAD || c == CL_JAL) ? 1 : 0) ||
                    o.wsel !== ((c == CL_LOAD) ? 2'd1 : (c == CL_JAL) ? 2'd2 : 2'd0)) begin
        failures++; $display("FAIL rnd%0d_rf: got we=%0d sel=%0d for class %0d", i, o.rf_wes, o.wsel, c); end
      checks++; if (o.dmem_reqs !== ((c == CL_LOAD || c == CL_STORE) ? dw + 1 : 0) ||
                    o.dmem_wes !== ((c == CL_STORE) ? dw + 1 : 0)) begin
        failures++; $display("FAIL rnd%0d_dmem: got req=%0d we=%0d for class %0d dw=%0d", i, o.dmem_reqs, o.dmem_wes, c, dw); end
    end
  endtask

  task automatic test_halt();
    obs_t o;
    exec_instr(32'h0000_0073, 0, 0, 1'b0, 32'h0, o);
    repeat (3) @(negedge clk);
    checks++; if (state !== ST_HALT || halted !== 1'b1 || pc !== model_pc) begin
      failures++; $display("FAIL halt: got st=%0d halted=%b pc=%0h want 6/1/%0h", state, halted, pc, model_pc); end
    go();
    model_pc = model_pc + 32'd4;
    checks++; if (state !== ST_FETCH || halted !== 1'b0 || pc !== model_pc) begin
      failures++; $display("FAIL resume: got st=%0d halted=%b pc=%0h want 1/0/%0h", state, halted, pc, model_pc); end
  endtask

  task automatic test_rst_mid();
    int n = 0;
    imem_rdata = 32'h0000_0003; imem_rvalid = 1;
    while (state !== ST_MEMORY && n < 10) begin @(negedge clk); imem_rvalid = 0; n++; end
    @(negedge clk);
    checks++; if (state !== ST_MEMORY || dmem_req !== 1'b1) begin failures++; $display("FAIL reach_memory: got st=%0d req=%b want 4/1", state, dmem_req); end
    rst = 1; #1;
    checks++; if (state !== ST_IDLE || pc !== 32'h0 || dmem_req !== 1'b0 || ir !== 32'h0) begin
      failures++; $display("FAIL rst_mid: got st=%0d pc=%0h req=%b ir=%0h want 0/0/0/0", state, pc, dmem_req, ir); end
    @(negedge clk); rst = 0; @(negedge clk);
  endtask

  task automatic test_illegal();
    obs_t o;
    do_reset(); go();
    exec_instr(32'h0000_007F, 0, 0, 1'b0, 32'h0, o);
    start = 1; repeat (3) @(negedge clk); start = 0;
    checks++; if (state !== ST_TRAP || trap !== 1'b1 || trap_cause !== 2'd0) begin
      failures++; $display("FAIL illegal_trap: got st=%0d trap=%b cause=%0d want 7/1/0", state, trap, trap_cause); end
  endtask

  task automatic test_imem_timeout();
    int n = 0;
    do_reset(); go();
    while (state === ST_FETCH && n < 40) begin start = 1'($urandom); @(negedge clk); n++; end
    start = 1; repeat (3) @(negedge clk); start = 0;
    checks++; if (n !== 17) begin failures++; $display("FAIL imem_timeout_cycles: got %0d want 17", n); end
    checks++; if (state !== ST_TRAP || trap !== 1'b1 || trap_cause !== 2'd1 || pc !== 32'h0) begin
      failures++; $display("FAIL imem_timeout_trap: got st=%0d trap=%b cause=%0d pc=%0h want 7/1/1/0", state, trap, trap_cause, pc); end
  endtask

  task automatic test_dmem_timeout();
    obs_t o;
    do_reset(); go();
    exec_instr(32'h0000_0023, 0, 1000, 1'b0, 32'h0, o);
    checks++; if (o.end_state !== ST_TRAP || trap_cause !== 2'd2 || o.dmem_reqs !== 17 || o.cycles !== 20) begin
      failures++; $display("FAIL dmem_timeout: got st=%0d cause=%0d req=%0d cyc=%0d want 7/2/17/20", o.end_state, trap_cause, o.dmem_reqs, o.cycles); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_branch();
    test_random();
    test_halt();
    test_rst_mid();
    test_illegal();
    test_imem_timeout();
    test_dmem_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
